// File: rtl/vu_level_sched.sv
// Per-frame VU-meter level scheduler: merges received level bytes and commits a
// decayed bar level plus a held peak marker once per vertical blank.
module vu_level_sched #(
   parameter int unsigned DATA_W      = 8,
   parameter int unsigned DECAY_STEP  = 4,
   parameter int unsigned HOLD_FRAMES = 30
) (
   input  logic              clk_board,
   input  logic              reset,
   input  logic              enable,
   input  logic [DATA_W-1:0] rx_data,
   input  logic              rx_valid,
   input  logic              frame_start,
   output logic [DATA_W-1:0] level,
   output logic [DATA_W-1:0] peak,
   output logic              level_upd,
   output logic              overrun
);

   localparam int unsigned        HOLD_W = $clog2(HOLD_FRAMES + 1);
   localparam logic [DATA_W-1:0]  STEP_C = DATA_W'(DECAY_STEP);
   localparam logic [HOLD_W-1:0]  HOLD_C = HOLD_W'(HOLD_FRAMES);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      CALC   = 2'd1,
      COMMIT = 2'd2
   } state_t;

   state_t              state_q, state_d;
   logic [DATA_W-1:0]   pending_q;
   logic                pending_valid_q;
   logic                overrun_q;
   logic [DATA_W-1:0]   level_q, peak_q;
   logic [DATA_W-1:0]   new_level_q, new_peak_q;
   logic                level_upd_q;
   logic [HOLD_W-1:0]   hold_cnt_q, hold_cnt_d;
   logic [DATA_W-1:0]   dec_s, peak_dec_s, new_level_s, new_peak_s;
   logic                rx_fire_s;

   function automatic logic [DATA_W-1:0] sat_sub(input logic [DATA_W-1:0] a);
      sat_sub = (a > STEP_C) ? (a - STEP_C) : {DATA_W{1'b0}};
   endfunction

   function automatic logic [DATA_W-1:0] max_of(input logic [DATA_W-1:0] a,
                                                input logic [DATA_W-1:0] b);
      max_of = (a > b) ? a : b;
   endfunction

   assign rx_fire_s = rx_valid & enable;

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (frame_start && enable) state_d = CALC; else state_d = IDLE;
         CALC:    state_d = COMMIT;
         COMMIT:  state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      dec_s       = sat_sub(level_q);
      peak_dec_s  = sat_sub(peak_q);
      new_level_s = pending_valid_q ? max_of(pending_q, dec_s) : dec_s;
      new_peak_s  = peak_q;
      hold_cnt_d  = hold_cnt_q;
      if (new_level_s >= peak_q) begin
         new_peak_s = new_level_s;
         hold_cnt_d = HOLD_C;
      end else if (hold_cnt_q != {HOLD_W{1'b0}}) begin
         new_peak_s = peak_q;
         hold_cnt_d = hold_cnt_q - HOLD_W'(1);
      end else begin
         new_peak_s = max_of(new_level_s, peak_dec_s);
         hold_cnt_d = hold_cnt_q;
      end
   end

   // Sample collection; the CALC cycle consumes pending and starts a fresh one.
   always_ff @(posedge clk_board or posedge reset) begin
      if (reset) begin
         pending_q       <= {DATA_W{1'b0}};
         pending_valid_q <= 1'b0;
         overrun_q       <= 1'b0;
      end else if (state_q == CALC) begin
         pending_valid_q <= rx_fire_s;
         if (rx_fire_s) pending_q <= rx_data;
      end else if (rx_fire_s) begin
         if (pending_valid_q) begin
            pending_q <= max_of(pending_q, rx_data);
            overrun_q <= 1'b1;
         end else begin
            pending_q       <= rx_data;
            pending_valid_q <= 1'b1;
         end
      end
   end

   always_ff @(posedge clk_board or posedge reset) begin
      if (reset) begin
         state_q     <= IDLE;
         new_level_q <= {DATA_W{1'b0}};
         new_peak_q  <= {DATA_W{1'b0}};
         hold_cnt_q  <= {HOLD_W{1'b0}};
         level_q     <= {DATA_W{1'b0}};
         peak_q      <= {DATA_W{1'b0}};
         level_upd_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         level_upd_q <= (state_q == COMMIT);
         if (state_q == CALC) begin
            new_level_q <= new_level_s;
            new_peak_q  <= new_peak_s;
            hold_cnt_q  <= hold_cnt_d;
         end
         if (state_q == COMMIT) begin
            level_q <= new_level_q;
            peak_q  <= new_peak_q;
         end
      end
   end

   assign level     = level_q;
   assign peak      = peak_q;
   assign level_upd = level_upd_q;
   assign overrun   = overrun_q;

endmodule

// File: tb/tb_vu_level_sched.sv
// Directed bench for vu_level_sched: expected commits are queued as frames are
// requested and checked when level_upd fires.
module tb_vu_level_sched;

   logic       clk_board = 1'b0;
   logic       reset, enable, rx_valid, frame_start;
   logic [7:0] rx_data;
   logic [7:0] level, peak;
   logic       level_upd, overrun;

   int checks = 0;
   int errors = 0;

   typedef struct packed {
      logic [7:0] lvl;
      logic [7:0] pk;
   } exp_t;
   exp_t exp_q[$];

   vu_level_sched #(.DATA_W(8), .DECAY_STEP(4), .HOLD_FRAMES(2)) dut (
      .clk_board  (clk_board),
      .reset      (reset),
      .enable     (enable),
      .rx_data    (rx_data),
      .rx_valid   (rx_valid),
      .frame_start(frame_start),
      .level      (level),
      .peak       (peak),
      .level_upd  (level_upd),
      .overrun    (overrun)
   );

   always #5 clk_board = ~clk_board;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Scoreboard: every commit pulse must match the oldest queued expectation.
   always @(negedge clk_board) begin
      if (level_upd === 1'b1) begin
         checks++;
         assert (exp_q.size() != 0) else begin
            errors++;
            $error("FAIL unexpected_upd observed level=0x%0h peak=0x%0h expected no commit", level, peak);
         end
         if (exp_q.size() != 0) begin
            exp_t e;
            e = exp_q.pop_front();
            chk("commit_level", {24'd0, level}, {24'd0, e.lvl});
            chk("commit_peak", {24'd0, peak}, {24'd0, e.pk});
            chk("peak_ge_level", {31'd0, (peak >= level)}, 32'd1);
         end
      end
   end

   task automatic do_reset();
      reset = 1'b1; enable = 1'b1; rx_valid = 1'b0; frame_start = 1'b0; rx_data = 8'h00;
      exp_q.delete();
      repeat (2) @(posedge clk_board);
      #1;
      chk("rst_level", {24'd0, level}, 32'd0);
      chk("rst_peak", {24'd0, peak}, 32'd0);
      chk("rst_upd", {31'd0, level_upd}, 32'd0);
      chk("rst_overrun", {31'd0, overrun}, 32'd0);
      reset = 1'b0;
   endtask

   task automatic send(input logic [7:0] d);
      @(posedge clk_board); #1 rx_valid = 1'b1; rx_data = d;
      @(posedge clk_board); #1 rx_valid = 1'b0;
   endtask

   // frame_start sampled on edge N; pulse expected only after edge N+2.
   task automatic do_frame(input bit rx_in_calc, input logic [7:0] d,
                           input bit exp_upd, input logic [7:0] el, input logic [7:0] ep);
      if (exp_upd) exp_q.push_back({el, ep});
      @(posedge clk_board); #1 frame_start = 1'b1;
      @(posedge clk_board); #1 frame_start = 1'b0; rx_valid = rx_in_calc; rx_data = d;
      @(negedge clk_board); chk("upd_after_N", {31'd0, level_upd}, 32'd0);
      @(posedge clk_board); #1 rx_valid = 1'b0;
      @(negedge clk_board); chk("upd_after_N1", {31'd0, level_upd}, 32'd0);
      @(negedge clk_board); chk("upd_after_N2", {31'd0, level_upd}, {31'd0, exp_upd});
      @(negedge clk_board); chk("upd_after_N3", {31'd0, level_upd}, 32'd0);
   endtask

   initial begin
      do_reset();
      // 1: empty frame
      do_frame(1'b0, 8'h00, 1'b1, 8'h00, 8'h00);
      chk("t1_overrun", {31'd0, overrun}, 32'd0);
      // 2: decay with peak hold of two frames
      send(8'hAA);
      do_frame(1'b0, 8'h00, 1'b1, 8'hAA, 8'hAA);
      do_frame(1'b0, 8'h00, 1'b1, 8'hA6, 8'hAA);
      do_frame(1'b0, 8'h00, 1'b1, 8'hA2, 8'hAA);
      do_frame(1'b0, 8'h00, 1'b1, 8'h9E, 8'hA6);
      chk("t2_overrun", {31'd0, overrun}, 32'd0);
      // 3: two samples merged in one frame
      send(8'h55);
      send(8'hAA);
      do_frame(1'b0, 8'h00, 1'b1, 8'hAA, 8'hAA);
      chk("t3_overrun", {31'd0, overrun}, 32'd1);
      // 4: sample beats decay, peak held
      send(8'hA8);
      do_frame(1'b0, 8'h00, 1'b1, 8'hA8, 8'hAA);
      chk("t4_overrun_sticky", {31'd0, overrun}, 32'd1);
      // 5: saturation at zero
      do_reset();
      send(8'h02);
      do_frame(1'b0, 8'h00, 1'b1, 8'h02, 8'h02);
      do_frame(1'b0, 8'h00, 1'b1, 8'h00, 8'h02);
      chk("t5_overrun", {31'd0, overrun}, 32'd0);
      // 6a: byte on the CALC cycle waits for the next frame
      do_frame(1'b1, 8'h30, 1'b1, 8'h00, 8'h02);
      do_frame(1'b0, 8'h00, 1'b1, 8'h30, 8'h30);
      // 6b: enable low ignores frame_start and samples
      enable = 1'b0;
      do_frame(1'b0, 8'h00, 1'b0, 8'h00, 8'h00);
      chk("en0_level", {24'd0, level}, 32'h30);
      chk("en0_peak", {24'd0, peak}, 32'h30);
      send(8'hF0);
      enable = 1'b1;
      do_frame(1'b0, 8'h00, 1'b1, 8'h2C, 8'h30);
      chk("en0_overrun", {31'd0, overrun}, 32'd0);
      // reset during CALC aborts the commit
      @(posedge clk_board); #1 frame_start = 1'b1;
      @(posedge clk_board); #1 frame_start = 1'b0; reset = 1'b1;
      repeat (3) begin
         @(negedge clk_board); chk("abort_upd", {31'd0, level_upd}, 32'd0);
      end
      reset = 1'b0;
      repeat (3) begin
         @(negedge clk_board); chk("abort_upd_after", {31'd0, level_upd}, 32'd0);
      end
      chk("abort_level", {24'd0, level}, 32'd0);
      chk("abort_peak", {24'd0, peak}, 32'd0);
      chk("queue_drained", exp_q.size(), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
